// File: rtl/gamma_pipe_razor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gamma_pipe_razor                                                       |
// | Two-stage branch-metric (gamma) pipeline with razor timing-error check |
// | Optional error counter: define GAMMA_ERR_CNT_EN                        |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module gamma_pipe_razor #(
  parameter int N        = 5,
  parameter int M        = 6,
  parameter int RazorBit = 1
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                nClear,
  input  logic                Enable,
  input  logic                Error_previous_Gamma,
  input  logic signed [N-1:0] a1,
  input  logic signed [N-1:0] a2,
  input  logic signed [N-1:0] a3,
  output logic signed [N-1:0] ba2,
  output logic signed [M:0]   ba1ba3,
  output logic signed [M:0]   ba1ba2ba3,
  output logic                Error_current_Gamma,
  output logic [7:0]          Err_Count
);

  localparam int c_sum_w  = (N + 2 > M + 1) ? N + 2 : M + 1;
  localparam int c_mon_n  = N - RazorBit;
  localparam int c_mon_m  = M + 1 - RazorBit;
  localparam logic signed [c_sum_w-1:0] c_sat_max = {{(c_sum_w - M){1'b0}}, {M{1'b1}}};
  localparam logic signed [c_sum_w-1:0] c_sat_min = {{(c_sum_w - M){1'b1}}, {M{1'b0}}};

  logic                      w_rst_n;
  logic                      w_upd;
  logic                      w_le;
  logic signed [N-1:0]       r_s1, r_s2, r_s3;
  logic signed [N-1:0]       r_ba2;
  logic signed [M:0]         r_ba13, r_ba123;
  logic signed [c_sum_w-1:0] w_s1x, w_s2x, w_s3x;
  logic signed [c_sum_w-1:0] w_sum13, w_sum123;
  logic signed [N-1:0]       w_b2;
  logic signed [M:0]         w_b13, w_b123;
  logic [2:0]                w_mon_comb;
  logic [2:0]                w_mon_reg;
  logic [2:0]                r_lat;

  assign w_rst_n = nReset & nClear;
  assign w_upd   = Enable & ~Error_previous_Gamma;
  assign w_le    = ~Enable & ~Error_previous_Gamma & Clock;

  function automatic logic signed [M:0] f_sat(input logic signed [c_sum_w-1:0] v);
    if (v > c_sat_max) begin
      return c_sat_max[M:0];
    end else if (v < c_sat_min) begin
      return c_sat_min[M:0];
    end
    return v[M:0];
  endfunction

  // Sums are formed at a common width wide enough for both the N+2 sum and the clamp limits
  assign w_s1x    = {{(c_sum_w - N){r_s1[N-1]}}, r_s1};
  assign w_s2x    = {{(c_sum_w - N){r_s2[N-1]}}, r_s2};
  assign w_s3x    = {{(c_sum_w - N){r_s3[N-1]}}, r_s3};
  assign w_sum13  = w_s1x + w_s3x;
  assign w_sum123 = w_s1x + w_s2x + w_s3x;
  assign w_b2     = r_s2;
  assign w_b13    = f_sat(w_sum13);
  assign w_b123   = f_sat(w_sum123);

  always_ff @(posedge Clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_ba2   <= '0;
      r_ba13  <= '0;
      r_ba123 <= '0;
    end else if (w_upd) begin
      r_s1    <= a1;
      r_s2    <= a2;
      r_s3    <= a3;
      r_ba2   <= w_b2;
      r_ba13  <= w_b13;
      r_ba123 <= w_b123;
    end
  end

  assign ba2       = r_ba2;
  assign ba1ba3    = r_ba13;
  assign ba1ba2ba3 = r_ba123;

  // Shadow latches sample the late-arriving stage-2 bit during the high phase
  assign w_mon_comb = {w_b123[c_mon_m], w_b13[c_mon_m], w_b2[c_mon_n]};
  assign w_mon_reg  = {r_ba123[c_mon_m], r_ba13[c_mon_m], r_ba2[c_mon_n]};

  always_latch begin
    if (!w_rst_n) begin
      r_lat <= '0;
    end else if (w_le) begin
      r_lat <= w_mon_comb;
    end
  end

  assign Error_current_Gamma = |(r_lat ^ w_mon_reg);

`ifdef GAMMA_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge Clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_err_cnt <= '0;
    end else if (Error_current_Gamma && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign Err_Count = r_err_cnt;
`else
  assign Err_Count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gamma_pipe_razor.sv
`default_nettype none
// Bench for gamma_pipe_razor: directed steps plus randomized traffic on an N=5 and an N=6 instance,
// checked against an arithmetic model of the pipeline, razor latches and error counter.
module tb_gamma_pipe_razor;

  localparam int M  = 6;
  localparam int RB = 1;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic nReset, nClear, Enable, Eprev;
  int   ain[2][3];

  logic signed [4:0] u5_a1, u5_a2, u5_a3, u5_ba2;
  logic signed [6:0] u5_ba13, u5_ba123;
  logic              u5_err;
  logic [7:0]        u5_cnt;
  logic signed [5:0] u6_a1, u6_a2, u6_a3, u6_ba2;
  logic signed [6:0] u6_ba13, u6_ba123;
  logic              u6_err;
  logic [7:0]        u6_cnt;

  assign u5_a1 = 5'(ain[0][0]);
  assign u5_a2 = 5'(ain[0][1]);
  assign u5_a3 = 5'(ain[0][2]);
  assign u6_a1 = 6'(ain[1][0]);
  assign u6_a2 = 6'(ain[1][1]);
  assign u6_a3 = 6'(ain[1][2]);

  gamma_pipe_razor u5 (
    .Clock(Clock), .nReset(nReset), .nClear(nClear), .Enable(Enable),
    .Error_previous_Gamma(Eprev), .a1(u5_a1), .a2(u5_a2), .a3(u5_a3),
    .ba2(u5_ba2), .ba1ba3(u5_ba13), .ba1ba2ba3(u5_ba123),
    .Error_current_Gamma(u5_err), .Err_Count(u5_cnt)
  );

  gamma_pipe_razor #(.N(6), .M(6)) u6 (
    .Clock(Clock), .nReset(nReset), .nClear(nClear), .Enable(Enable),
    .Error_previous_Gamma(Eprev), .a1(u6_a1), .a2(u6_a2), .a3(u6_a3),
    .ba2(u6_ba2), .ba1ba3(u6_ba13), .ba1ba2ba3(u6_ba123),
    .Error_current_Gamma(u6_err), .Err_Count(u6_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model state: stage-1 samples, registered outputs, latched bits, counter bounds
  int ms[2][3];
  int mo[2][3];
  bit ml[2][3];
  int clo[2];
  int chi[2];

  function automatic int nw(int k);
    return (k == 0) ? 5 : 6;
  endfunction

  function automatic int ow(int k, int j);
    return (j == 0) ? nw(k) : M + 1;
  endfunction

  function automatic int sat(int v);
    if (v > (1 << M) - 1) return (1 << M) - 1;
    if (v < -(1 << M)) return -(1 << M);
    return v;
  endfunction

  function automatic int comb(int k, int j);
    if (j == 0) return ms[k][1];
    if (j == 1) return sat(ms[k][0] + ms[k][2]);
    return sat(ms[k][0] + ms[k][1] + ms[k][2]);
  endfunction

  function automatic bit mon(int v, int w);
    return ((v >>> (w - RB)) & 1) != 0;
  endfunction

  function automatic bit merr(int k);
    bit e = 1'b0;
    for (int j = 0; j < 3; j++)
      if (ml[k][j] != mon(mo[k][j], ow(k, j))) e = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        ms[k][j] = 0;
        mo[k][j] = 0;
        ml[k][j] = 1'b0;
      end
      clo[k] = 0;
      chi[k] = 0;
    end
  endtask

  // Counter samples the pre-edge flag; a latch capture at the same edge may be seen either way
  task automatic model_edge();
    bit upd, le, e_pre, e_alt;
    int c[3];
    upd = Enable && !Eprev;
    le  = !Enable && !Eprev;
    for (int k = 0; k < 2; k++) begin
      e_pre = merr(k);
      if (upd) begin
        for (int j = 0; j < 3; j++) c[j] = comb(k, j);
        for (int j = 0; j < 3; j++) begin
          mo[k][j] = c[j];
          ms[k][j] = ain[k][j];
        end
      end
      if (le)
        for (int j = 0; j < 3; j++) ml[k][j] = mon(comb(k, j), ow(k, j));
      e_alt = le ? merr(k) : e_pre;
`ifdef GAMMA_ERR_CNT_EN
      if (e_pre && e_alt && clo[k] < 255) clo[k]++;
      if ((e_pre || e_alt) && chi[k] < 255) chi[k]++;
`else
      e_alt = e_alt;
`endif
    end
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    checks++;
    assert ((obs >= 32'(lo)) && (obs <= 32'(hi))) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_u5_ba2"}, u5_ba2, mo[0][0]);
    chk({ph, "_u5_ba13"}, u5_ba13, mo[0][1]);
    chk({ph, "_u5_ba123"}, u5_ba123, mo[0][2]);
    chk({ph, "_u5_err"}, {31'd0, u5_err}, int'(merr(0)));
    chk_rng({ph, "_u5_cnt"}, {24'd0, u5_cnt}, clo[0], chi[0]);
    chk({ph, "_u6_ba2"}, u6_ba2, mo[1][0]);
    chk({ph, "_u6_ba13"}, u6_ba13, mo[1][1]);
    chk({ph, "_u6_ba123"}, u6_ba123, mo[1][2]);
    chk({ph, "_u6_err"}, {31'd0, u6_err}, int'(merr(1)));
    chk_rng({ph, "_u6_cnt"}, {24'd0, u6_cnt}, clo[1], chi[1]);
  endtask

  task automatic cycle(input string ph);
    @(posedge Clock);
    model_edge();
    #1;
    check_all(ph);
    @(negedge Clock);
  endtask

  task automatic set_in(input int k, input int x1, input int x2, input int x3);
    ain[k][0] = x1;
    ain[k][1] = x2;
    ain[k][2] = x3;
  endtask

  function automatic int rnd(int n);
    return int'($urandom_range(0, (1 << n) - 1)) - (1 << (n - 1));
  endfunction

  int snap[3];
  bit snap_err;
  int prev_cnt;

  initial begin
    nReset = 1'b1;
    nClear = 1'b1;
    Enable = 1'b0;
    Eprev  = 1'b0;
    set_in(0, 0, 0, 0);
    set_in(1, 0, 0, 0);
    #1 nReset = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge Clock);
    @(negedge Clock);
    nReset = 1'b1;

    // Two updates of +15 (N=5) and +31 (N=6, saturating)
    Enable = 1'b1;
    set_in(0, 15, 15, 15);
    set_in(1, 31, 31, 31);
    cycle("lat1");
    cycle("lat2");
    chk("r029_ba2", u5_ba2, 15);
    chk("r029_ba13", u5_ba13, 30);
    chk("r029_ba123", u5_ba123, 45);
    chk("r029_err", {31'd0, u5_err}, 0);
    chk("r030_pos_sat", u6_ba123, 63);

    set_in(1, -32, -32, -32);
    cycle("neg1");
    cycle("neg2");
    chk("r030_neg_sat", u6_ba123, -64);

    // Stalled by the previous stage: nothing may move
    for (int j = 0; j < 3; j++) snap[j] = mo[0][j];
    snap_err = merr(0);
    Eprev = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Enable = 1'($urandom_range(0, 1));
      set_in(0, rnd(5), rnd(5), rnd(5));
      set_in(1, rnd(6), rnd(6), rnd(6));
      cycle("stall");
    end
    chk("r031_ba2", u5_ba2, snap[0]);
    chk("r031_ba13", u5_ba13, snap[1]);
    chk("r031_ba123", u5_ba123, snap[2]);
    chk("r031_err", {31'd0, u5_err}, int'(snap_err));
    Eprev = 1'b0;

    // Make only the ba1ba3 shadow bit disagree, then idle with latches open
    Enable = 1'b1;
    set_in(0, -1, 15, -1);
    cycle("force_ld");
    Enable = 1'b0;
    cycle("force0");
    chk("r032_err", {31'd0, u5_err}, 1);
    for (int i = 0; i < 300; i++) begin
      prev_cnt = int'(u5_cnt);
      cycle("force");
`ifdef GAMMA_ERR_CNT_EN
      chk("r032_step", {24'd0, u5_cnt}, (prev_cnt < 255) ? prev_cnt + 1 : 255);
`else
      chk("r034_zero", {24'd0, u5_cnt}, 0);
`endif
    end
`ifdef GAMMA_ERR_CNT_EN
    chk("r032_sat", {24'd0, u5_cnt}, 255);
`else
    chk("r034_final", {24'd0, u5_cnt}, 0);
`endif

    // Asynchronous clear in the middle of the low phase
    #2 nClear = 1'b0;
    #1;
    model_reset();
    check_all("clear");
    #1 nClear = 1'b1;

    for (int i = 0; i < 250; i++) begin
      Enable = ($urandom_range(0, 3) != 0);
      Eprev  = ($urandom_range(0, 4) == 0);
      set_in(0, rnd(5), rnd(5), rnd(5));
      set_in(1, rnd(6), rnd(6), rnd(6));
      if ($urandom_range(0, 39) == 0) begin
        #2;
        if ($urandom_range(0, 1) == 0) nReset = 1'b0;
        else nClear = 1'b0;
        #1;
        model_reset();
        check_all("rnd_rst");
        #1;
        nReset = 1'b1;
        nClear = 1'b1;
      end
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gamma_pipe_razor.md
GAMMA_PIPE_RAZOR -- requirements
Module: gamma_pipe_razor

Interface
REQ-001 The block SHALL have parameter N, default 5, meaning the width of the signed input LLRs and of ba2.
REQ-002 The block SHALL have parameter M, default 6, meaning that ba1ba3 and ba1ba2ba3 are M+1 bits wide.
REQ-003 The block SHALL have parameter RazorBit, default 1, meaning the monitored bit of each output is at index W-RazorBit, where W is that output's width.
REQ-004 Port Clock, input, 1 bit: the single clock.
REQ-005 Port nReset, input, 1 bit: asynchronous active-low reset.
REQ-006 Port nClear, input, 1 bit: asynchronous active-low clear, with the same effect as nReset.
REQ-007 Port Enable, input, 1 bit: stage update enable.
REQ-008 Port Error_previous_Gamma, input, 1 bit: timing error reported by the preceding stage.
REQ-009 Ports a1, a2, a3, input, N bits each, signed: systematic, a-priori and parity LLRs respectively.
REQ-010 Port ba2, output, N bits, signed: registered branch metric.
REQ-011 Ports ba1ba3 and ba1ba2ba3, output, M+1 bits each, signed: registered branch metrics.
REQ-012 Port Error_current_Gamma, output, 1 bit: razor timing-error flag for this stage.
REQ-013 Port Err_Count, output, 8 bits: saturating count of timing-error cycles.

Function
REQ-014 Define upd = Enable && !Error_previous_Gamma; a state element SHALL load only on a rising Clock edge where upd=1, and SHALL otherwise hold its value.
REQ-015 Stage 1 SHALL register a1, a2 and a3 into s1, s2 and s3 on each update.
REQ-016 Stage 2 combinational results:
  - b2 = s2.
  - b13 = s1+s3, computed at N+1 bits.
  - b123 = s1+s2+s3, computed at N+2 bits.
  - All sums use signed extension.
REQ-017 b13 and b123 SHALL each be saturated to M+1 bits, clamping to the range [-2^M, 2^M-1].
REQ-018 Stage 2 SHALL register b2, b13 and b123 into ba2, ba1ba3 and ba1ba2ba3 on each update.
REQ-019 Latency SHALL be exactly 2 update edges from a sample on a1..a3 to the matching values on the outputs.
REQ-020 Razor latch enable SHALL be le = !Enable && !Error_previous_Gamma && Clock.
REQ-021 While le=1, one transparent latch per output SHALL capture the monitored bit (index W-RazorBit) of the stage-2 combinational value for that output.
REQ-022 Error_current_Gamma SHALL be the OR, over the three outputs, of (latched bit XOR the registered output's monitored bit).
REQ-023 With Error_previous_Gamma=1, neither the registers nor the latches SHALL change, regardless of Enable.
REQ-024 On each rising edge where Error_current_Gamma=1, Err_Count SHALL increment by 1, saturating at 255 with no wrap.

Reset
REQ-025 While nReset=0 or nClear=0, asynchronously:
  - s1, s2, s3, all outputs, all razor latches and Err_Count SHALL be 0.
  - Error_current_Gamma SHALL be 0.
REQ-026 Reset or clear asserted mid-operation SHALL discard any in-flight sample; there SHALL be no partial update.
REQ-027 After release, the first valid outputs SHALL appear on the second update edge.

Configuration
REQ-028 Macro GAMMA_ERR_CNT_EN SHALL control the error counter.
  - Defined: Err_Count is implemented per REQ-024.
  - Undefined: Err_Count is tied to 0 and no counter flops are inferred.
  - All other behaviour SHALL be identical in both builds.

Verification
REQ-029 N=5, M=6, a1=a2=a3=15, two update edges -> ba2=15, ba1ba3=30, ba1ba2ba3=45, Error_current_Gamma=0.
REQ-030 N=6, M=6, a1=a2=a3=31 -> ba1ba2ba3=63 (saturated); then a1=a2=a3=-32 -> ba1ba2ba3=-64.
REQ-031 Hold Error_previous_Gamma=1 for 3 edges with a1..a3 changing -> outputs and latches unchanged.
REQ-032 Force the latched monitored bit of ba1ba3 to differ from its flop -> Error_current_Gamma=1.
  - Err_Count increments per edge.
  - After 300 error edges, Err_Count=255 (build with GAMMA_ERR_CNT_EN defined).
REQ-033 Pulse nClear low asynchronously between clock edges -> all outputs, Err_Count and Error_current_Gamma read 0 immediately.
REQ-034 Build without GAMMA_ERR_CNT_EN and repeat REQ-032 -> Err_Count=0 throughout.
